muldiv_sequencer: RTL and testbench

//  Iterative RV32M multiply/divide engine with its own sequencing FSM. Sits in EX beside the ALU.

---
 rtl/muldiv_pkg.sv | 23 ++
 rtl/muldiv_sign_unit.sv | 30 +++
 rtl/muldiv_sequencer.sv | 260 ++++++++++++++++++++++++++
 tb/tb_muldiv_sequencer.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared definitions for the RV32M multiply/divide sequencer.
package muldiv_pkg;

    localparam int DEF_XLEN  = 32;
    localparam int DEF_CNT_W = 6;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_CALC = 2'b01,
        S_FIX  = 2'b10,
        S_DONE = 2'b11
    } state_t;

endpackage

// File: rtl/muldiv_sign_unit.sv
// Sign handling for the sequencer: operand magnitude/sign capture on the input
// side and conditional two's-complement negation of the double-width result.
module muldiv_sign_unit
    import muldiv_pkg::*;
#(
    parameter int XLEN = DEF_XLEN
) (
    input  logic [XLEN-1:0]   a,
    input  logic [XLEN-1:0]   b,
    input  logic              a_signed,
    input  logic              b_signed,
    output logic [XLEN-1:0]   a_abs,
    output logic [XLEN-1:0]   b_abs,
    output logic              a_neg,
    output logic              b_neg,
    input  logic [2*XLEN-1:0] fix_val,
    input  logic              fix_neg,
    output logic [2*XLEN-1:0] fix_out
);

    localparam logic [XLEN-1:0]   ONE_X  = {{(XLEN-1){1'b0}}, 1'b1};
    localparam logic [2*XLEN-1:0] ONE_2X = {{(2*XLEN-1){1'b0}}, 1'b1};

    assign a_neg   = a_signed & a[XLEN-1];
    assign b_neg   = b_signed & b[XLEN-1];
    assign a_abs   = a_neg ? (~a + ONE_X) : a;
    assign b_abs   = b_neg ? (~b + ONE_X) : b;
    assign fix_out = fix_neg ? (~fix_val + ONE_2X) : fix_val;

endmodule

// File: rtl/muldiv_sequencer.sv
// Iterative RV32M multiply/divide engine with its own sequencing FSM.
// Optional single-cycle multiply path enabled by defining MULDIV_FAST_MUL_EN.
module muldiv_sequencer
    import muldiv_pkg::*;
#(
    parameter int XLEN  = DEF_XLEN,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] rs1_val,
    input  logic [XLEN-1:0] rs2_val,
    input  logic            flush,
    output logic            stall,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [XLEN-1:0]  ZERO_X   = {XLEN{1'b0}};
    localparam logic [XLEN-1:0]  ONES_X   = {XLEN{1'b1}};
    localparam logic [XLEN-1:0]  MIN_X    = {1'b1, {(XLEN-1){1'b0}}};

    state_t              state_r;
    state_t              next_state_s;
    logic [CNT_W-1:0]    cnt_r;
    logic [2:0]          f3_r;
    logic                neg_r;
    logic [XLEN-1:0]     op_r;
    logic [XLEN-1:0]     acc_r;
    logic [XLEN-1:0]     lo_r;
    logic                busy_r;
    logic                done_r;
    logic [XLEN-1:0]     result_r;

    logic                a_signed_s;
    logic                b_signed_s;
    logic [XLEN-1:0]     a_abs_s;
    logic [XLEN-1:0]     b_abs_s;
    logic                a_neg_s;
    logic                b_neg_s;
    logic                neg_s;
    logic                div_zero_s;
    logic                ovf_s;
    logic                special_s;
    logic [XLEN-1:0]     special_res_s;
    logic                load_s;
    logic                step_s;
    logic                fix_s;
    logic                busy_s;
    logic                done_s;
    logic [XLEN:0]       mul_sum_s;
    logic [XLEN:0]       div_shift_s;
    logic [XLEN:0]       div_trial_s;
    logic [XLEN-1:0]     acc_next_s;
    logic [XLEN-1:0]     lo_next_s;
    logic [2*XLEN-1:0]   fix_val_s;
    logic [2*XLEN-1:0]   fix_out_s;
    logic [XLEN-1:0]     fix_res_s;

    muldiv_sign_unit #(.XLEN(XLEN)) u_sign (
        .a        (rs1_val),
        .b        (rs2_val),
        .a_signed (a_signed_s),
        .b_signed (b_signed_s),
        .a_abs    (a_abs_s),
        .b_abs    (b_abs_s),
        .a_neg    (a_neg_s),
        .b_neg    (b_neg_s),
        .fix_val  (fix_val_s),
        .fix_neg  (neg_r),
        .fix_out  (fix_out_s)
    );

    // Operand signedness per opcode; MUL keeps unsigned since its low half is sign-agnostic.
    always_comb begin
        a_signed_s = 1'b0;
        b_signed_s = 1'b0;
        case (funct3)
            F3_MULH:   begin a_signed_s = 1'b1; b_signed_s = 1'b1; end
            F3_MULHSU: begin a_signed_s = 1'b1; b_signed_s = 1'b0; end
            F3_DIV:    begin a_signed_s = 1'b1; b_signed_s = 1'b1; end
            F3_REM:    begin a_signed_s = 1'b1; b_signed_s = 1'b1; end
            default:   begin a_signed_s = 1'b0; b_signed_s = 1'b0; end
        endcase
    end

    assign neg_s      = (funct3[2] & funct3[1]) ? a_neg_s : (a_neg_s ^ b_neg_s);
    assign div_zero_s = (rs2_val == ZERO_X);
    assign ovf_s      = ~funct3[0] & (rs1_val == MIN_X) & (rs2_val == ONES_X);
    assign special_s  = funct3[2] & (div_zero_s | ovf_s);

    // Result for the divide corner cases that bypass the iterative datapath.
    always_comb begin
        special_res_s = ZERO_X;
        if (div_zero_s) begin
            special_res_s = funct3[1] ? rs1_val : ONES_X;
        end else begin
            special_res_s = funct3[1] ? ZERO_X : rs1_val;
        end
    end

`ifdef MULDIV_FAST_MUL_EN
    logic [2*XLEN-1:0] fast_prod_s;
    assign fast_prod_s = {ZERO_X, a_abs_s} * {ZERO_X, b_abs_s};
`endif

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // FSM next-state logic; flush wins over every other condition.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (start & ~flush) begin
                    if (special_s) begin
                        next_state_s = S_DONE;
                    end
`ifdef MULDIV_FAST_MUL_EN
                    else if (!funct3[2]) begin
                        next_state_s = S_FIX;
                    end
`endif
                    else begin
                        next_state_s = S_CALC;
                    end
                end else begin
                    next_state_s = S_IDLE;
                end
            end
            S_CALC: begin
                if (flush) begin
                    next_state_s = S_IDLE;
                end else if (cnt_r == CNT_LAST) begin
                    next_state_s = S_FIX;
                end else begin
                    next_state_s = S_CALC;
                end
            end
            S_FIX: begin
                if (flush) begin
                    next_state_s = S_IDLE;
                end else begin
                    next_state_s = S_DONE;
                end
            end
            S_DONE:  next_state_s = S_IDLE;
            default: next_state_s = S_IDLE;
        endcase
    end

    // FSM outputs: datapath enables and next values of the registered status flags.
    always_comb begin
        load_s = (state_r == S_IDLE) & start & ~flush;
        step_s = (state_r == S_CALC) & ~flush;
        fix_s  = (state_r == S_FIX) & ~flush;
        busy_s = (next_state_s != S_IDLE);
        done_s = (next_state_s == S_DONE);
    end

    // One iteration: shift-add multiply (acc:lo is the product) or restoring divide step.
    always_comb begin
        mul_sum_s   = {1'b0, acc_r} + (lo_r[0] ? {1'b0, op_r} : {(XLEN+1){1'b0}});
        div_shift_s = {acc_r, lo_r[XLEN-1]};
        div_trial_s = div_shift_s - {1'b0, op_r};
        if (f3_r[2]) begin
            if (!div_trial_s[XLEN]) begin
                acc_next_s = div_trial_s[XLEN-1:0];
                lo_next_s  = {lo_r[XLEN-2:0], 1'b1};
            end else begin
                acc_next_s = div_shift_s[XLEN-1:0];
                lo_next_s  = {lo_r[XLEN-2:0], 1'b0};
            end
        end else begin
            acc_next_s = mul_sum_s[XLEN:1];
            lo_next_s  = {mul_sum_s[0], lo_r[XLEN-1:1]};
        end
    end

    // Sign fix-up input and final result selection.
    always_comb begin
        if (f3_r[2]) begin
            fix_val_s = {ZERO_X, (f3_r[1] ? acc_r : lo_r)};
        end else begin
            fix_val_s = {acc_r, lo_r};
        end
        if (f3_r[2] | (f3_r == F3_MUL)) begin
            fix_res_s = fix_out_s[XLEN-1:0];
        end else begin
            fix_res_s = fix_out_s[2*XLEN-1:XLEN];
        end
    end

    // Datapath, counter and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r    <= CNT_ZERO;
            f3_r     <= 3'b000;
            neg_r    <= 1'b0;
            op_r     <= ZERO_X;
            acc_r    <= ZERO_X;
            lo_r     <= ZERO_X;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            result_r <= ZERO_X;
        end else begin
            busy_r <= busy_s;
            done_r <= done_s;
            cnt_r  <= step_s ? (cnt_r + CNT_ONE) : CNT_ZERO;
            if (load_s) begin
                f3_r  <= funct3;
                neg_r <= neg_s;
                op_r  <= funct3[2] ? b_abs_s : a_abs_s;
`ifdef MULDIV_FAST_MUL_EN
                if (funct3[2]) begin
                    acc_r <= ZERO_X;
                    lo_r  <= a_abs_s;
                end else begin
                    acc_r <= fast_prod_s[2*XLEN-1:XLEN];
                    lo_r  <= fast_prod_s[XLEN-1:0];
                end
`else
                acc_r <= ZERO_X;
                lo_r  <= funct3[2] ? a_abs_s : b_abs_s;
`endif
            end else if (step_s) begin
                acc_r <= acc_next_s;
                lo_r  <= lo_next_s;
            end else begin
                acc_r <= acc_r;
                lo_r  <= lo_r;
            end
            if (load_s & special_s) begin
                result_r <= special_res_s;
            end else if (fix_s) begin
                result_r <= fix_res_s;
            end else begin
                result_r <= result_r;
            end
        end
    end

    assign stall  = start & ~done_r;
    assign busy   = busy_r;
    assign done   = done_r;
    assign result = result_r;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Scoreboard bench for muldiv_sequencer: driver queues expected results, a
// negedge monitor pops and compares value and latency on every done pulse.
module tb_muldiv_sequencer;
    import muldiv_pkg::*;

`ifdef MULDIV_FAST_MUL_EN
    localparam int MUL_LAT = 2;
`else
    localparam int MUL_LAT = 34;
`endif
    localparam int DIV_LAT = 34;
    localparam int SPC_LAT = 1;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [2:0]  funct3;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic        flush;
    logic        stall;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        logic [31:0] exp;
        int          lat;
        int          acc;
        string       name;
    } exp_t;

    exp_t        sb_q[$];
    exp_t        mon_e;
    logic [31:0] saved;

    muldiv_sequencer dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .funct3  (funct3),
        .rs1_val (rs1_val),
        .rs2_val (rs2_val),
        .flush   (flush),
        .stall   (stall),
        .busy    (busy),
        .done    (done),
        .result  (result)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every done pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (done === 1'b1) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: result=%h with nothing outstanding", result);
            end else begin
                mon_e = sb_q.pop_front();
                chk({mon_e.name, "_result"}, result, mon_e.exp);
                chk({mon_e.name, "_latency"}, 32'(cyc - mon_e.acc + 1), 32'(mon_e.lat));
            end
        end
    end

    task automatic do_op(input string name, input logic [2:0] f, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp, input int lat);
        int st_cnt;
        int n;
        @(posedge clk); #1;
        funct3 = f; rs1_val = a; rs2_val = b; start = 1'b1;
        @(posedge clk); #1;
        sb_q.push_back('{exp, lat, cyc, name});
        st_cnt = 0;
        n = 0;
        while (done !== 1'b1 && n < 200) begin
            if (stall === 1'b1) st_cnt++;
            @(posedge clk); #1;
            n++;
        end
        if (done !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: no done after %0d cycles", name, n);
        end
        chk({name, "_stall_cycles"}, 32'(st_cnt), 32'(lat - 1));
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; start = 1'b0; flush = 1'b0;
        funct3 = 3'b000; rs1_val = 32'h0; rs2_val = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_busy",   32'(busy),  32'h0);
        chk("reset_done",   32'(done),  32'h0);
        chk("reset_stall",  32'(stall), 32'h0);
        chk("reset_result", result,     32'h0);
        rst = 1'b0;

        do_op("mul_7_m3",       F3_MUL,    32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, MUL_LAT);
        do_op("mul_6_7",        F3_MUL,    32'h0000_0006, 32'h0000_0007, 32'h0000_002A, MUL_LAT);
        do_op("mul_big",        F3_MUL,    32'h1234_5678, 32'h0000_0010, 32'h2345_6780, MUL_LAT);
        do_op("mulhu_ones",     F3_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, MUL_LAT);
        do_op("mulh_min_min",   F3_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, MUL_LAT);
        do_op("mulhsu_m1_max",  F3_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, MUL_LAT);
        do_op("mulh_m2_3",      F3_MULH,   32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFF, MUL_LAT);
        do_op("mulhu_2p31_4",   F3_MULHU,  32'h8000_0000, 32'h0000_0004, 32'h0000_0002, MUL_LAT);
        do_op("div_m7_2",       F3_DIV,    32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, DIV_LAT);
        do_op("rem_m7_2",       F3_REM,    32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, DIV_LAT);
        do_op("div_7_m2",       F3_DIV,    32'h0000_0007, 32'hFFFF_FFFE, 32'hFFFF_FFFD, DIV_LAT);
        do_op("rem_7_m2",       F3_REM,    32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, DIV_LAT);
        do_op("divu_100_7",     F3_DIVU,   32'd100,       32'd7,         32'd14,        DIV_LAT);
        do_op("remu_100_7",     F3_REMU,   32'd100,       32'd7,         32'd2,         DIV_LAT);
        do_op("divu_min_ones",  F3_DIVU,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, DIV_LAT);
        do_op("remu_min_ones",  F3_REMU,   32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, DIV_LAT);
        do_op("div_5_0",        F3_DIV,    32'd5,         32'd0,         32'hFFFF_FFFF, SPC_LAT);
        do_op("rem_5_0",        F3_REM,    32'd5,         32'd0,         32'd5,         SPC_LAT);
        do_op("divu_5_0",       F3_DIVU,   32'd5,         32'd0,         32'hFFFF_FFFF, SPC_LAT);
        do_op("remu_5_0",       F3_REMU,   32'd5,         32'd0,         32'd5,         SPC_LAT);
        do_op("div_ovf",        F3_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, SPC_LAT);
        do_op("rem_ovf",        F3_REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, SPC_LAT);

        // flush asserted together with start in IDLE: nothing is accepted
        @(posedge clk); #1;
        funct3 = F3_DIVU; rs1_val = 32'd50; rs2_val = 32'd5; start = 1'b1; flush = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; flush = 1'b0;
        chk("flush_over_start_busy", 32'(busy), 32'h0);

        // flush ten cycles into a DIV
        @(posedge clk); #1;
        funct3 = F3_DIV; rs1_val = 32'hFFFF_FF9C; rs2_val = 32'd7; start = 1'b1;
        @(posedge clk); #1;
        saved = result;
        repeat (10) @(posedge clk);
        #1;
        chk("flush_pre_busy", 32'(busy), 32'h1);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0; start = 1'b0;
        chk("flush_busy",   32'(busy), 32'h0);
        chk("flush_done",   32'(done), 32'h0);
        chk("flush_result", result,    saved);
        repeat (4) @(posedge clk);
        do_op("divu_9_3", F3_DIVU, 32'd9, 32'd3, 32'd3, DIV_LAT);

        // synchronous reset in the middle of CALC
        @(posedge clk); #1;
        funct3 = F3_DIV; rs1_val = 32'd100; rs2_val = 32'd7; start = 1'b1;
        @(posedge clk); #1;
        repeat (5) @(posedge clk);
        #1;
        chk("rst_pre_busy", 32'(busy), 32'h1);
        rst = 1'b1; start = 1'b0;
        @(posedge clk); #1;
        chk("rst_mid_busy",   32'(busy),  32'h0);
        chk("rst_mid_done",   32'(done),  32'h0);
        chk("rst_mid_stall",  32'(stall), 32'h0);
        chk("rst_mid_result", result,     32'h0);
        rst = 1'b0;
        do_op("remu_after_rst", F3_REMU, 32'd100, 32'd7, 32'd2, DIV_LAT);

        repeat (5) @(posedge clk);
        #1;
        chk("scoreboard_empty", 32'(sb_q.size()), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
